// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory-port arbiter.
// Round-robin arbitration is compiled in only when ARB_ROUND_ROBIN_EN is defined.
package mem_port_arbiter_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      WAIT = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      INST = 2'd1,
      DATA = 2'd2
   } owner_t;

   // Bit positions inside the one-hot grant vector
   localparam int GNT_INST = 0;
   localparam int GNT_DATA = 1;

   localparam logic LAST_INST = 1'b0;
   localparam logic LAST_DATA = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Shared SRAM-like memory port between the arbiter (master) and the memory bridge (slave).
// Build option: ARB_ROUND_ROBIN_EN (affects the arbiter only, not this interface).
interface mem_port_arbiter_if
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);

   logic                  mem_req;
   logic                  mem_wr;
   logic [DATA_W/8-1:0]   mem_wstrb;
   logic [ADDR_W-1:0]     mem_addr;
   logic [DATA_W-1:0]     mem_wdata;
   logic                  mem_addr_ok;
   logic                  mem_data_ok;
   logic [DATA_W-1:0]     mem_rdata;

   modport master (
      output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
      input  mem_addr_ok, mem_data_ok, mem_rdata
   );

   modport slave (
      input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
      output mem_addr_ok, mem_data_ok, mem_rdata
   );

endinterface

// File: rtl/mem_port_arbiter_arb_grant.sv
// Combinational winner select between the instruction and data requesters.
// With ARB_ROUND_ROBIN_EN defined, ties go to the requester not granted last; otherwise data wins.
module arb_grant
   import mem_port_arbiter_pkg::*;
(
   input  logic       inst_req,
   input  logic       data_req,
`ifdef ARB_ROUND_ROBIN_EN
   input  logic       last_grant,
`endif
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      if (data_req && inst_req) begin
`ifdef ARB_ROUND_ROBIN_EN
         if (last_grant == LAST_DATA)
            grant[GNT_INST] = 1'b1;
         else
            grant[GNT_DATA] = 1'b1;
`else
         grant[GNT_DATA] = 1'b1;
`endif
      end else if (data_req) begin
         grant[GNT_DATA] = 1'b1;
      end else if (inst_req) begin
         grant[GNT_INST] = 1'b1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like port between IF fetches and EX/MEM data accesses, one transaction at a time.
// Build option: ARB_ROUND_ROBIN_EN selects round-robin tie-breaking instead of data-first priority.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic                clk,
   input  logic                rst,

   input  logic                inst_req,
   input  logic [ADDR_W-1:0]   inst_addr,
   output logic                inst_addr_ok,
   output logic                inst_data_ok,
   output logic [DATA_W-1:0]   inst_rdata,

   input  logic                data_req,
   input  logic                data_wr,
   input  logic [DATA_W/8-1:0] data_wstrb,
   input  logic [ADDR_W-1:0]   data_addr,
   input  logic [DATA_W-1:0]   data_wdata,
   output logic                data_addr_ok,
   output logic                data_data_ok,
   output logic [DATA_W-1:0]   data_rdata,

   mem_port_arbiter_if.master  mem,

   output logic                stallreq_for_mem
);

   state_t              state_q, state_d;
   owner_t              owner_q, owner_d;
   logic                wr_q, wr_d;
   logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [1:0]          grant;
   logic                complete;

`ifdef ARB_ROUND_ROBIN_EN
   logic                last_grant_q, last_grant_d;
`endif

   arb_grant u_arb_grant (
      .inst_req   (inst_req),
      .data_req   (data_req),
`ifdef ARB_ROUND_ROBIN_EN
      .last_grant (last_grant_q),
`endif
      .grant      (grant)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         owner_q <= NONE;
         wr_q    <= 1'b0;
         wstrb_q <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         last_grant_q <= LAST_INST;
`endif
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         wr_q    <= wr_d;
         wstrb_q <= wstrb_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
`ifdef ARB_ROUND_ROBIN_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

   // Grant only from IDLE, so a new grant lands no earlier than the cycle after completion
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      wr_d         = wr_q;
      wstrb_d      = wstrb_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      inst_addr_ok = 1'b0;
      data_addr_ok = 1'b0;
      complete     = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_d = last_grant_q;
`endif
      case (state_q)
         IDLE: begin
            if (grant != 2'b00) begin
               inst_addr_ok = grant[GNT_INST];
               data_addr_ok = grant[GNT_DATA];
               owner_d      = grant[GNT_DATA] ? DATA : INST;
               wr_d         = grant[GNT_DATA] ? data_wr : 1'b0;
               wstrb_d      = grant[GNT_DATA] ? data_wstrb : '0;
               addr_d       = grant[GNT_DATA] ? data_addr : inst_addr;
               wdata_d      = grant[GNT_DATA] ? data_wdata : '0;
               state_d      = ADDR;
`ifdef ARB_ROUND_ROBIN_EN
               last_grant_d = grant[GNT_DATA] ? LAST_DATA : LAST_INST;
`endif
            end
         end
         ADDR: begin
            if (mem.mem_addr_ok) begin
               if (mem.mem_data_ok) begin
                  complete = 1'b1;
                  owner_d  = NONE;
                  state_d  = IDLE;
               end else begin
                  state_d  = WAIT;
               end
            end
         end
         WAIT: begin
            if (mem.mem_data_ok) begin
               complete = 1'b1;
               owner_d  = NONE;
               state_d  = IDLE;
            end
         end
         default: begin
            owner_d = NONE;
            state_d = IDLE;
         end
      endcase
   end

   assign mem.mem_req   = (state_q == ADDR);
   assign mem.mem_wr    = (state_q == ADDR) & wr_q;
   assign mem.mem_wstrb = (state_q == ADDR) ? wstrb_q : '0;
   assign mem.mem_addr  = (state_q == ADDR) ? addr_q  : '0;
   assign mem.mem_wdata = (state_q == ADDR) ? wdata_q : '0;

   assign inst_data_ok = complete & (owner_q == INST);
   assign data_data_ok = complete & (owner_q == DATA);

   // Read data is steered only to the current owner; the other side sees zero
   assign inst_rdata = ((state_q != IDLE) && (owner_q == INST)) ? mem.mem_rdata : '0;
   assign data_rdata = ((state_q != IDLE) && (owner_q == DATA)) ? mem.mem_rdata : '0;

   assign stallreq_for_mem = (data_req & ~data_addr_ok)
                           | ((state_q != IDLE) & (owner_q == DATA) & ~data_data_ok);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one SRAM-like memory port between the IF-stage instruction requester and the EX/MEM-stage data requester.
- Grants one requester at a time, registers the granted transaction and drives it onto the shared port.
- Routes the response back to the granted requester and raises a stall request to CTRL while a data access is pending.
- Sits between the core's inst/data request interfaces and the unified external memory bridge.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (byte strobes = DATA_W/8)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
inst_req  in  1  instruction fetch request (read only)
inst_addr  in  ADDR_W  fetch address
inst_addr_ok  out  1  fetch request accepted (grant pulse)
inst_data_ok  out  1  fetch data valid
inst_rdata  out  DATA_W  fetch data
data_req  in  1  data access request
data_wr  in  1  1 = write, 0 = read
data_wstrb  in  DATA_W/8  byte write strobes
data_addr  in  ADDR_W  data address
data_wdata  in  DATA_W  write data
data_addr_ok  out  1  data request accepted (grant pulse)
data_data_ok  out  1  read data valid / write done
data_rdata  out  DATA_W  read data
mem_req  out  1  shared-port request
mem_wr  out  1  shared-port write
mem_wstrb  out  DATA_W/8  shared-port strobes
mem_addr  out  ADDR_W  shared-port address
mem_wdata  out  DATA_W  shared-port write data
mem_addr_ok  in  1  port accepted the request
mem_data_ok  in  1  port response valid
mem_rdata  in  DATA_W  port read data
stallreq_for_mem  out  1  stall request to CTRL

Behaviour:
- Clocking and reset: single clock clk; rst is synchronous, active-high.
- Reset state: state=IDLE, owner=NONE, all latched fields 0. mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata, all *_addr_ok, all *_data_ok and stallreq_for_mem are 0.
- States:
  - IDLE: no transaction held.
  - ADDR: mem_req held high until mem_addr_ok.
  - WAIT: waiting for mem_data_ok.
- IDLE, grant cycle:
  - If any request is pending, select a winner. Default is fixed priority: data beats inst.
  - Pulse the winner's *_addr_ok combinationally in that same cycle.
  - Latch wr, wstrb, addr, wdata and owner; go to ADDR next cycle.
  - Inst grants always latch wr=0 and wstrb=0.
- ADDR:
  - mem_* outputs are driven from the latched registers and are stable until mem_addr_ok.
  - mem_addr_ok alone → WAIT.
  - mem_addr_ok and mem_data_ok in the same cycle → complete immediately and go to IDLE.
- WAIT: on mem_data_ok, complete and go to IDLE.
- Completion:
  - The owner's *_data_ok equals mem_data_ok for exactly one cycle.
  - *_rdata passes mem_rdata through combinationally; the non-owner's *_rdata is 0.
- One outstanding transaction at most. The next grant can occur no earlier than the cycle after completion.
- Minimum latency: grant at T, mem_req at T+1, data_ok at T+1 (zero-wait port) or later.
- mem_data_ok while in IDLE is ignored; it produces no *_data_ok.
- A requester must hold req and its fields until it sees addr_ok; the arbiter does not check this.
- stallreq_for_mem = (data_req & ~data_addr_ok) | (state!=IDLE & owner==DATA & ~data_data_ok).
- Inst-side waiting is handled by IF's own handshake; it does not raise stallreq_for_mem.
- Reset mid-operation: return to IDLE and drop mem_req the next cycle. Any later response is discarded under the IDLE rule.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: when both requests are pending in IDLE, the winner is the requester that was NOT granted last. A 1-bit last_grant register resets to INST, so data wins first.
- Undefined: fixed data-over-inst priority, and no last_grant register exists.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=2'd0, ADDR=2'd1, WAIT=2'd2
  - owner encoding: NONE, INST, DATA
  - ADDR_W and DATA_W defaults
- Sub-module arb_grant: combinational winner select from inst_req, data_req and last_grant (with the round-robin option); outputs one-hot grant.
- The FSM and latches stay in mem_port_arbiter.

Test Plan:
1. Zero-wait port, inst_req only, addr 0xBFC00000, mem_rdata 0x3C1D0001 → inst_addr_ok at T; mem_req at T+1 with mem_wr=0; inst_data_ok=1 and inst_rdata=0x3C1D0001 at T+1; state IDLE at T+2.
2. Both requests at T, data write addr 0x80000010, wstrb 0xF, wdata 0xDEADBEEF → data_addr_ok at T, inst_addr_ok=0. mem_wr=1 with those fields at T+1. Inst is granted in the cycle after data completes.
3. Port asserts mem_addr_ok after 3 cycles and mem_data_ok 2 cycles later → mem_req stays high with stable fields for 3 cycles; stallreq_for_mem=1 until data_data_ok.
4. Inject mem_data_ok while IDLE → no *_data_ok pulse and no state change.
5. rst asserted during WAIT → next cycle mem_req=0, state IDLE, all outputs 0; a response arriving afterwards is ignored.
6. With ARB_ROUND_ROBIN_EN, both requests held continuously → grants alternate DATA, INST, DATA, INST. Without the macro, DATA is granted every time.
